turn_input_latch: RTL and testbench
===================================

Name: turn_input_latch

Overview:
Upstream feeder for the game datapath's turn[5:0] input (currently tied to 6'b000000). Converts held-key levels from the PS/2 keyboard LUT into per-player one-shot turn commands. Each command is latched between game ticks and presented as a stable vector for exactly one tick window. Sits between the keyboard controller and game_data, clocked on CLOCK_50 with the 20 Hz tick as a strobe.

Parameters:
NUM_PLAYERS, 3, number of players; turn width is 2*NUM_PLAYERS.

Ports:
CLOCK_50  in  1  system clock, 50 MHz
reset_n  in  1  synchronous, active-low reset
game_tick  in  1  one-CLOCK_50-cycle strobe, 20 Hz (counter==0)
run_game  in  1  high while the game FSM is in G_GAME
key_down  in  2*NUM_PLAYERS  held-key levels; bit 2p = player p right key, bit 2p+1 = player p left key
turn  out  2*NUM_PLAYERS  per player: 01 right, 10 left, 00 none; player p occupies bits [2p+1:2p]
turn_dropped  out  1  one-cycle pulse when any key edge is discarded

Behaviour:
- Reset (reset_n=0 at a CLOCK_50 edge): turn=0, turn_dropped=0, all pending slots empty. key_prev loads the current key_down, so keys held through reset never generate turns.
- Edge detect: key_prev <= key_down every cycle. A key "press" is key_down & ~key_prev. Only rising edges count; holding a key yields one turn.
- Per-player pending slot, 2 bits, 00 = empty:
  - A press into an empty slot stores that direction.
  - A press into a full slot is discarded and pulses turn_dropped.
  - Right and left pressed in the same cycle cancel each other. The slot is unchanged and turn_dropped pulses.
- Tick, on a cycle with game_tick=1 and run_game=1:
  - turn <= pending for all players.
  - All slots cleared.
  - A press arriving in the same cycle as the tick goes into the freshly cleared slot, so it lands in the next window.
- turn holds its value for the whole window until the next tick; output latency is one tick window. The consumer samples turn on its own tick edge.
- run_game=0: turn is forced to 0 on the next edge, slots are cleared each cycle, and presses are ignored (no turn_dropped). key_prev keeps tracking.
- run_game rising mid-window: slots start empty and the first tick emits whatever was pressed since.
- reset_n=0 mid-window overrides everything, including a coincident tick.
- All outputs are registered; there is no combinational path from inputs to turn.

Optional Feature:
TURN_QUEUE_EN
- Defined: each player slot becomes a 2-entry FIFO.
  - A press pushes to the tail.
  - A tick pops the head to turn and shifts the second entry to the head, so it is emitted on the following tick.
  - Two presses of the same direction in one window produce a U-turn over two ticks.
  - Push when full is dropped and pulses turn_dropped.
  - Push and pop in the same cycle are both honoured.
  - run_game=0 or reset flushes both entries.
- Undefined: single-entry slot exactly as in Behaviour.

Decomposition:
- Shared package lightbike_pkg holds the turn encodings: TURN_NONE=2'b00, TURN_RIGHT=2'b01, TURN_LEFT=2'b10. The same package also holds the direction encoding (00 up, 01 right, 10 down, 11 left) so game_data uses the same constants.
- One natural sub-module: turn_slot, the per-player slot or FIFO, instantiated NUM_PLAYERS times in a generate loop. The top level owns edge detect, run_game gating and the turn_dropped OR-reduction.

Test Plan:
- Reset with key_down=6'b000001 held, release reset, tick -> turn=6'b000000, no drop.
- run_game=1; key_down bit0 rises 0->1 mid-window, tick -> turn=6'b000001 for one full window; next tick -> turn=6'b000000.
- Player 1 presses left then right in one window (bits 3 then 2) -> tick gives turn[3:2]=2'b10, turn_dropped pulses once at the right press. With TURN_QUEUE_EN, the next tick gives 2'b01 instead, with no drop.
- Player 2 bits 4 and 5 rise in the same cycle -> turn_dropped=1 for one cycle; tick gives turn[5:4]=2'b00.
- Press on player 0 coincident with game_tick -> that tick emits 00 for player 0; the following tick emits 01.
- run_game falls while a slot is pending -> turn=0 next cycle; run_game rises, tick with no presses -> turn=0.

Source files
------------

// File: rtl/lightbike_pkg.sv
// Shared lightbike encodings: per-player turn commands and heading directions,
// used by turn_input_latch and game_data alike.
package lightbike_pkg;

  typedef enum logic [1:0] {
    TURN_NONE  = 2'b00,
    TURN_RIGHT = 2'b01,
    TURN_LEFT  = 2'b10
  } turn_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  // Press pair {left, right} maps straight onto the turn encoding; both or neither is no turn.
  function automatic turn_e press_to_turn(input logic [1:0] press);
    case (press)
      2'b01:   return TURN_RIGHT;
      2'b10:   return TURN_LEFT;
      default: return TURN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/turn_input_latch_if.sv
// Keyboard-to-game turn command bus: held keys and tick strobes in, per-window turns out.
interface turn_input_latch_if #(
  parameter int unsigned NUM_PLAYERS = 3
);
  logic                       game_tick;
  logic                       run_game;
  logic [2*NUM_PLAYERS-1:0]   key_down;
  logic [2*NUM_PLAYERS-1:0]   turn;
  logic                       turn_dropped;

  modport master (
    output game_tick, run_game, key_down,
    input  turn, turn_dropped
  );

  modport slave (
    input  game_tick, run_game, key_down,
    output turn, turn_dropped
  );
endinterface

// File: rtl/turn_slot.sv
// Per-player pending turn storage: single slot, or a 2-entry FIFO when
// TURN_QUEUE_EN is defined.
module turn_slot
  import lightbike_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       flush,
  input  logic       pop,
  input  logic [1:0] press,
  output turn_e      head,
  output logic       dropped
);

  turn_e req;
  logic  cancel;

  assign req    = press_to_turn(press);
  assign cancel = &press;

`ifdef TURN_QUEUE_EN
  turn_e q0, q1, q0_n, q1_n, s0, s1;

  // Pop is applied first so a push in the tick cycle sees the shifted queue.
  always_comb begin
    s0      = q0;
    s1      = q1;
    dropped = 1'b0;
    if (pop) begin
      s0 = q1;
      s1 = TURN_NONE;
    end
    q0_n = s0;
    q1_n = s1;
    if (cancel) begin
      dropped = 1'b1;
    end else if (req != TURN_NONE) begin
      if (s0 == TURN_NONE)      q0_n = req;
      else if (s1 == TURN_NONE) q1_n = req;
      else                      dropped = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n || flush) begin
      q0 <= TURN_NONE;
      q1 <= TURN_NONE;
    end else begin
      q0 <= q0_n;
      q1 <= q1_n;
    end
  end

  assign head = q0;
`else
  turn_e slot, slot_n, base;

  always_comb begin
    base    = pop ? TURN_NONE : slot;
    slot_n  = base;
    dropped = 1'b0;
    if (cancel) begin
      dropped = 1'b1;
    end else if (req != TURN_NONE) begin
      if (base == TURN_NONE) slot_n  = req;
      else                   dropped = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n || flush) slot <= TURN_NONE;
    else                   slot <= slot_n;
  end

  assign head = slot;
`endif

endmodule

// File: rtl/turn_input_latch.sv
// Converts held-key levels into one-shot per-player turns, latched once per game tick.
// Optional macro TURN_QUEUE_EN turns each player slot into a 2-entry FIFO.
module turn_input_latch
  import lightbike_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = 3
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  turn_input_latch_if.slave bus
);

  localparam int unsigned W = 2 * NUM_PLAYERS;

  logic [W-1:0]           key_prev;
  logic [W-1:0]           press;
  logic [W-1:0]           heads;
  logic [NUM_PLAYERS-1:0] drops;
  logic                   pop;
  logic                   flush;

  // key_prev tracks in reset and while idle so held keys never count as presses.
  always_ff @(posedge CLOCK_50) begin
    key_prev <= bus.key_down;
  end

  assign press = bus.run_game ? (bus.key_down & ~key_prev) : '0;
  assign pop   = bus.game_tick & bus.run_game;
  assign flush = ~bus.run_game;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_slot
    turn_slot u_slot (
      .CLOCK_50 (CLOCK_50),
      .reset_n  (reset_n),
      .flush    (flush),
      .pop      (pop),
      .press    (press[2*p+1:2*p]),
      .head     (heads[2*p+1:2*p]),
      .dropped  (drops[p])
    );
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      bus.turn         <= '0;
      bus.turn_dropped <= 1'b0;
    end else begin
      bus.turn_dropped <= |drops;
      if (!bus.run_game)     bus.turn <= '0;
      else if (bus.game_tick) bus.turn <= heads;
    end
  end

endmodule

// File: tb/tb_turn_input_latch.sv
// Scoreboard bench for turn_input_latch: stimulus queues expected turn/drop
// results per output event; a negedge monitor pops and compares them.
module tb_turn_input_latch;
  localparam int unsigned NP = 3;
  localparam int unsigned W  = 2 * NP;

  logic CLOCK_50 = 1'b0;
  logic reset_n;

  turn_input_latch_if #(.NUM_PLAYERS(NP)) bus ();

  turn_input_latch #(.NUM_PLAYERS(NP)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [W-1:0] turn;
    int           drops;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // An output event: reset edge, qualified tick, or run_game falling.
  logic         ev_flag = 1'b0;
  logic         run_q   = 1'b0;
  int           drop_cnt = 0;
  logic [W-1:0] hold = '0;

  always @(posedge CLOCK_50) begin
    ev_flag <= !reset_n || (bus.run_game && bus.game_tick) || (!bus.run_game && run_q);
    run_q   <= bus.run_game;
  end

  always @(negedge CLOCK_50) begin
    exp_t e;
    if (ev_flag) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event t=%0t turn=%b", $time, bus.turn);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (bus.turn !== e.turn) begin
          errors++;
          $display("FAIL turn t=%0t got=%b exp=%b", $time, bus.turn, e.turn);
        end
        checks++;
        if (drop_cnt != e.drops) begin
          errors++;
          $display("FAIL drops t=%0t got=%0d exp=%0d", $time, drop_cnt, e.drops);
        end
        hold = e.turn;
      end
      drop_cnt = 0;
    end else begin
      checks++;
      if (bus.turn !== hold) begin
        errors++;
        $display("FAIL hold t=%0t got=%b exp=%b", $time, bus.turn, hold);
      end
    end
    if (bus.turn_dropped === 1'b1) drop_cnt++;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic expect_ev(input logic [W-1:0] t, input int d);
    exp_t e;
    e.turn  = t;
    e.drops = d;
    exp_q.push_back(e);
  endtask

  task automatic do_tick(input logic [W-1:0] t, input int d);
    expect_ev(t, d);
    bus.game_tick = 1'b1;
    @(negedge CLOCK_50);
    bus.game_tick = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n       = 1'b0;
    bus.run_game  = 1'b1;
    bus.game_tick = 1'b0;
    bus.key_down  = 6'b000001;

    // Key held through reset must not generate a turn.
    for (int unsigned i = 0; i < 3; i++) begin
      expect_ev('0, 0);
      @(negedge CLOCK_50);
    end
    reset_n = 1'b1;
    cycles(3);
    do_tick(6'b000000, 0);

    // Single press: one window of 01, then back to none.
    bus.key_down = '0;
    cycles(2);
    bus.key_down = 6'b000001;
    cycles(3);
    do_tick(6'b000001, 0);
    cycles(5);
    do_tick(6'b000000, 0);
    bus.key_down = '0;
    cycles(2);

    // Player 1 left then right in one window.
    bus.key_down = 6'b001000;
    cycles(2);
    bus.key_down = 6'b001100;
    cycles(3);
`ifdef TURN_QUEUE_EN
    do_tick(6'b001000, 0);
    cycles(3);
    do_tick(6'b000100, 0);
`else
    do_tick(6'b001000, 1);
    cycles(3);
    do_tick(6'b000000, 0);
`endif
    bus.key_down = '0;
    cycles(2);

    // Player 2 both keys in the same cycle cancel.
    bus.key_down = 6'b110000;
    cycles(3);
    do_tick(6'b000000, 1);
    bus.key_down = '0;
    cycles(2);

    // Press coincident with the tick lands in the next window.
    bus.key_down = 6'b000001;
    do_tick(6'b000000, 0);
    cycles(3);
    do_tick(6'b000001, 0);
    bus.key_down = '0;
    cycles(2);

    // run_game falls with a pending slot; presses while idle are ignored.
    bus.key_down = 6'b000001;
    cycles(2);
    expect_ev('0, 0);
    bus.run_game = 1'b0;
    cycles(2);
    bus.key_down = 6'b000011;
    cycles(2);
    bus.game_tick = 1'b1;
    cycles(1);
    bus.game_tick = 1'b0;
    cycles(2);
    bus.run_game = 1'b1;
    cycles(3);
    do_tick(6'b000000, 0);
    bus.key_down = '0;
    cycles(2);

    // Reset coincident with a tick overrides it and clears the pending press.
    bus.key_down = 6'b010000;
    cycles(2);
    expect_ev('0, 0);
    reset_n       = 1'b0;
    bus.game_tick = 1'b1;
    @(negedge CLOCK_50);
    reset_n       = 1'b1;
    bus.game_tick = 1'b0;
    cycles(2);
    do_tick(6'b000000, 0);
    bus.key_down = '0;
    cycles(2);

    // All three players turning in the same window.
    bus.key_down = 6'b100101;
    cycles(3);
    do_tick(6'b100101, 0);
    bus.key_down = '0;
    cycles(3);
    do_tick(6'b000000, 0);
    cycles(3);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations got=%0d exp=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
